// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit path.
// Holds the TX frame state enum, the default data width and the serial line levels.
// Imported by the frame controller and its serializer.
package uart_tx_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// Shift register plus bit counter for the data portion of a UART frame.
// Ports: clk_i/rst_i, load_i (capture data_i and clear the counter), shift_en_i (one DATA cycle),
//        data_i, ser_bit_o (bit the line takes on the coming edge), ser_done_o (last data bit).
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  shift_en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ser_bit_o,
  output logic                  ser_done_o
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shift_d = data_i;
      cnt_d   = '0;
    end else if (shift_en_i) begin
      shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
      cnt_d   = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // The line is registered, so the controller needs the bit that will be
  // visible after the coming edge: during a DATA cycle the register is about
  // to shift, so that is shift_q[1]; before the first shift it is shift_q[0].
  assign ser_bit_o  = shift_en_i ? shift_q[1] : shift_q[0];
  assign ser_done_o = (cnt_q == CW'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART TX frame controller: start bit, data LSB-first, optional parity, stop bit, one bit per CLK.
// Ports: CLK/RST (async, active-high), P_DATA/Data_Valid/PAR_EN accepted in IDLE only,
//        Par_Bit sampled entering PARITY; TX_OUT (registered, idles high), Busy (registered).
module uart_tx_frame_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  Par_Bit,
  output logic                  TX_OUT,
  output logic                  Busy
);

  tx_state_e state_q, state_d;
  logic      tx_q, tx_d;
  logic      busy_q, busy_d;
  logic      par_en_q;
  logic      accept;
  logic      shift_en;
  logic      ser_bit;
  logic      ser_done;

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ser (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (accept),
    .shift_en_i (shift_en),
    .data_i     (P_DATA),
    .ser_bit_o  (ser_bit),
    .ser_done_o (ser_done)
  );

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    shift_en = (state_q == DATA);
    tx_d     = LINE_IDLE;

    case (state_q)
      IDLE: begin
        if (Data_Valid) begin
          accept  = 1'b1;
          state_d = START;
        end
      end
      START:  state_d = DATA;
      DATA: begin
        if (ser_done) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: state_d = STOP;
      STOP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    case (state_d)
      START:   tx_d = START_BIT;
      DATA:    tx_d = ser_bit;
      PARITY:  tx_d = Par_Bit;
      STOP:    tx_d = STOP_BIT;
      default: tx_d = LINE_IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      tx_q     <= LINE_IDLE;
      busy_q   <= 1'b0;
      par_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      if (accept) par_en_q <= PAR_EN;
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule
